data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
// data_memory_responder: single-outstanding load/store responder in front of a
// word-organised data RAM, with a configurable number of wait states per request.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam int         WORDS     = 1 << IDX_W;
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
    logic misaligned;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return misaligned || ((addr >> ADDR_WIDTH) != 32'd0);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sign_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: res = {{16{sign_ext & h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_s;
  logic             we_r;
  logic             signed_r;
  logic [1:0]       size_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic             resp_valid_r;
  logic             resp_err_r;
  logic [31:0]      resp_rdata_r;
  logic [31:0]      mem_r [WORDS];

  logic             accept_s;
  logic             do_access_s;
  logic             mem_we_s;
  logic             acc_we_s;
  logic             acc_signed_s;
  logic             acc_err_s;
  logic [1:0]       acc_size_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      ld_data_s;
  logic [3:0]       be_s;
  logic [31:0]      st_data_s;

  assign req_ready  = cpu_rst && ((state_r == ST_IDLE) || ((state_r == ST_RESP) && resp_ready));
  assign accept_s   = req_valid && req_ready;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Access operands: latched request while waiting, live request when there are no wait states
  always_comb begin
    if (state_r == ST_WAIT) begin
      acc_we_s     = we_r;
      acc_size_s   = size_r;
      acc_signed_s = signed_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
    end else begin
      acc_we_s     = req_we;
      acc_size_s   = req_size;
      acc_signed_s = req_signed;
      acc_addr_s   = req_addr;
      acc_wdata_s  = req_wdata;
    end
  end

  assign acc_idx_s   = acc_addr_s[ADDR_WIDTH-1:2];
  assign acc_err_s   = access_error(acc_size_s, acc_addr_s);
  assign rd_word_s   = mem_r[acc_idx_s];
  assign ld_data_s   = load_extract(rd_word_s, acc_size_s, acc_addr_s[1:0], acc_signed_s);
  assign be_s        = store_be(acc_size_s, acc_addr_s[1:0]);
  assign st_data_s   = store_data(acc_size_s, acc_wdata_s);
  assign do_access_s = ((state_r == ST_WAIT) && (cnt_r == 4'd0)) || (accept_s && NO_WAIT);
  // A store only commits when no reset lands on the edge that would enter RESP.
  assign mem_we_s    = cpu_rst && do_access_s && acc_we_s && !acc_err_s;

  // Next-state and wait-counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = NO_WAIT ? ST_RESP : ST_WAIT;
          cnt_s   = WAIT_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (accept_s) begin
          state_s = NO_WAIT ? ST_RESP : ST_WAIT;
          cnt_s   = WAIT_LOAD;
        end else if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Control state, request capture and registered response
  always_ff @(posedge clk) begin
    if (!cpu_rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      resp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        we_r     <= req_we;
        size_r   <= req_size;
        signed_r <= req_signed;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
      end
      if (do_access_s) begin
        resp_err_r   <= acc_err_s;
        resp_rdata_r <= (acc_we_s || acc_err_s) ? 32'd0 : ld_data_s;
      end
    end
  end

  // Byte-enabled RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_s && be_s[b]) begin
        mem_r[acc_idx_s][8*b +: 8] <= st_data_s[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
// Bench for data_memory_responder: instances with 1, 0 and 3 wait states share
// clock and reset; only the instance picked by sel sees req_valid.
module tb_data_memory_responder;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [1:0]  sel;

  logic        rr [3];
  logic        rv [3];
  logic        re [3];
  logic [31:0] rd [3];
  logic        s_rr;
  logic        s_rv;
  logic        s_re;
  logic [31:0] s_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .ADDR_WIDTH (12),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .cpu_rst   (cpu_rst),
      .req_valid (req_valid && (sel == 2'(g))),
      .req_ready (rr[g]),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(rv[g]),
      .resp_ready(resp_ready),
      .resp_rdata(rd[g]),
      .resp_err  (re[g])
    );
  end

  assign s_rr = rr[sel];
  assign s_rv = rv[sel];
  assign s_re = re[sel];
  assign s_rd = rd[sel];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One request/response on the selected instance; lat = edge index (after acceptance)
  // at which resp_valid is first seen high.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output int wait_n);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    wait_n = 0;
    while (!s_rr && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!s_rr) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, want high", wait_n);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!s_rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = s_rd;
    err   = s_re;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdat;
    logic        er;
    int          lat;
    int          wn;

    sel = 2'd0;
    vecs.push_back(mk("ld_word",           1'b0, W,     1'b0, 32'h010,      32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("st_byte",           1'b1, B,     1'b0, 32'h012,      32'h00000080, 32'h0,        1'b0));
    vecs.push_back(mk("ld_byte_s",         1'b0, B,     1'b1, 32'h012,      32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk("ld_byte_u",         1'b0, B,     1'b0, 32'h012,      32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk("ld_word_merged",    1'b0, W,     1'b0, 32'h010,      32'h0,        32'hDE80BEEF, 1'b0));
    vecs.push_back(mk("ld_half_s",         1'b0, H,     1'b1, 32'h012,      32'h0,        32'hFFFFDE80, 1'b0));
    vecs.push_back(mk("ld_word_misal",     1'b0, W,     1'b0, 32'h011,      32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("st_half_misal",     1'b1, H,     1'b0, 32'h013,      32'h0000FFFF, 32'h0,        1'b1));
    vecs.push_back(mk("ld_word_unchanged", 1'b0, W,     1'b0, 32'h010,      32'h0,        32'hDE80BEEF, 1'b0));
    vecs.push_back(mk("size_illegal",      1'b0, 2'b11, 1'b0, 32'h010,      32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("ld_out_of_range",   1'b0, W,     1'b0, 32'h00001000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("st_out_of_range",   1'b1, W,     1'b0, 32'h80000010, 32'h11111111, 32'h0,        1'b1));
    vecs.push_back(mk("ld_half_u",         1'b0, H,     1'b0, 32'h010,      32'h0,        32'h0000BEEF, 1'b0));
    vecs.push_back(mk("st_half_lo",        1'b1, H,     1'b0, 32'h010,      32'hFFFF1234, 32'h0,        1'b0));
    vecs.push_back(mk("ld_word_signed",    1'b0, W,     1'b1, 32'h010,      32'h0,        32'hDE801234, 1'b0));
    vecs.push_back(mk("ld_byte_s_pos",     1'b0, B,     1'b1, 32'h011,      32'h0,        32'h00000012, 1'b0));
    vecs.push_back(mk("st_byte_lane3",     1'b1, B,     1'b0, 32'h013,      32'h0000017F, 32'h0,        1'b0));
    vecs.push_back(mk("ld_word_lane3",     1'b0, W,     1'b0, 32'h010,      32'h0,        32'h7F801234, 1'b0));
    vecs.push_back(mk("ld_half_s_pos",     1'b0, H,     1'b1, 32'h012,      32'h0,        32'h00007F80, 1'b0));

    // Reset held for 3 cycles with a store already presented
    cpu_rst = 1'b0; resp_ready = 1'b1; req_valid = 1'b1;
    req_we = 1'b1; req_size = W; req_signed = 1'b0; req_addr = 32'h010; req_wdata = 32'hDEADBEEF;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_req_ready",  32'(s_rr), 32'd0);
      check("rst_resp_valid", 32'(s_rv), 32'd0);
      check("rst_rdata",      s_rd,      32'd0);
      check("rst_err",        32'(s_re), 32'd0);
    end
    cpu_rst = 1'b1;
    xact(1'b1, W, 1'b0, 32'h010, 32'hDEADBEEF, rdat, er, lat, wn);
    check("first_accept_wait", 32'(wn), 32'd0);
    check("st_word_latency",   32'(lat), 32'd2);
    check("st_word_err",       32'(er), 32'd0);
    check("st_word_rdata",     rdat, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      xact(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rdat, er, lat, wn);
      check({vecs[i].name, "_rdata"}, rdat, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
    end

    // Back-pressure and chaining with no wait states
    sel = 2'd1;
    xact(1'b1, W, 1'b0, 32'h040, 32'hA5A50F0F, rdat, er, lat, wn);
    check("ws0_st_latency", 32'(lat), 32'd1);
    check("ws0_st_err",     32'(er), 32'd0);
    req_we = 1'b0; req_size = W; req_signed = 1'b0; req_addr = 32'h040;
    resp_ready = 1'b0; req_valid = 1'b1;
    #1;
    check("bp_idle_ready", 32'(s_rr), 32'd1);
    @(posedge clk); #1;
    req_size = B; req_addr = 32'h042;
    repeat (5) begin
      check("bp_resp_valid", 32'(s_rv), 32'd1);
      check("bp_rdata",      s_rd,      32'hA5A50F0F);
      check("bp_err",        32'(s_re), 32'd0);
      check("bp_req_ready",  32'(s_rr), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    check("chain_req_ready", 32'(s_rr), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("chain_resp_valid", 32'(s_rv), 32'd1);
    check("chain_rdata",      s_rd,      32'h000000A5);
    check("chain_err",        32'(s_re), 32'd0);
    @(posedge clk); #1;
    check("chain_drain_valid", 32'(s_rv), 32'd0);

    // Reset during the second wait cycle of a store with three wait states
    sel = 2'd2;
    xact(1'b1, W, 1'b0, 32'h020, 32'hCAFEF00D, rdat, er, lat, wn);
    check("ws3_st_latency", 32'(lat), 32'd4);
    req_we = 1'b1; req_size = W; req_signed = 1'b0; req_addr = 32'h020; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    cpu_rst = 1'b0;
    #1;
    check("midrst_req_ready", 32'(s_rr), 32'd0);
    @(posedge clk); #1;
    cpu_rst = 1'b1;
    check("midrst_resp_valid", 32'(s_rv), 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_resp", 32'(s_rv), 32'd0);
    end
    xact(1'b0, W, 1'b0, 32'h020, 32'h0, rdat, er, lat, wn);
    check("midrst_ld_rdata",   rdat, 32'hCAFEF00D);
    check("midrst_ld_err",     32'(er), 32'd0);
    check("midrst_ld_latency", 32'(lat), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
